// File: rtl/exception_commit_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : exception_commit_unit_if
// Description : Bundle of the commit-slot inputs, CP0 status inputs and the
//               registered exception decision outputs of the exception
//               commit unit.
//               slave  - the view of the exception commit unit itself
//               master - the view of the pipeline / environment driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface exception_commit_unit_if #(
    parameter int NUM_SLOTS = 2,
    parameter int EXC_W     = 19,
    parameter int CODE_W    = 5
);
    localparam int c_slot_w = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // Commit-slot side
    logic [NUM_SLOTS-1:0]       Slot_Valid;
    logic [NUM_SLOTS*EXC_W-1:0] Slot_ExcBits;
    logic [NUM_SLOTS*32-1:0]    Slot_PC;
    logic [NUM_SLOTS-1:0]       Slot_InDelay;
    logic                       MEM_Stall;

    // Interrupt and CP0 status
    logic                       Interrupt_Req;
    logic                       CP0_Status_IE;
    logic                       CP0_Status_EXL;
    logic                       CP0_Status_BEV;
    logic [31:0]                CP0_Ebase;

    // Registered decision
    logic                       Flush_Exception;
    logic [CODE_W-1:0]          MEM_ExcType;
    logic [1:0]                 EX_Entry_Sel;
    logic [31:0]                Exception_Vector;
    logic [31:0]                Exc_EPC;
    logic                       Exc_BD;
    logic [c_slot_w-1:0]        Exc_Slot;

    modport master (
        output Slot_Valid, Slot_ExcBits, Slot_PC, Slot_InDelay, MEM_Stall,
        output Interrupt_Req, CP0_Status_IE, CP0_Status_EXL, CP0_Status_BEV, CP0_Ebase,
        input  Flush_Exception, MEM_ExcType, EX_Entry_Sel, Exception_Vector,
        input  Exc_EPC, Exc_BD, Exc_Slot
    );

    modport slave (
        input  Slot_Valid, Slot_ExcBits, Slot_PC, Slot_InDelay, MEM_Stall,
        input  Interrupt_Req, CP0_Status_IE, CP0_Status_EXL, CP0_Status_BEV, CP0_Ebase,
        output Flush_Exception, MEM_ExcType, EX_Entry_Sel, Exception_Vector,
        output Exc_EPC, Exc_BD, Exc_Slot
    );
endinterface
`default_nettype wire

// File: rtl/exception_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : exception_commit_unit
// Description : Registered multi-slot exception arbiter at the MEM1/commit
//               boundary. Picks the oldest valid slot carrying an exception
//               (or the pending interrupt), the highest-priority cause in that
//               slot, computes the handler vector / EPC / BD, issues a
//               one-cycle flush and then ignores the slots for DRAIN_CYC
//               cycles while the pipeline empties.
// Ports       : clk  - clock
//               rst  - synchronous reset, active-high
//               bus  - exception_commit_unit_if.slave: slot valid/cause/PC/
//                      delay-slot inputs, stall, interrupt request, CP0
//                      status/Ebase inputs; flush, cause code, entry select,
//                      vector, EPC, BD and slot-index outputs
// Revision    : 1.0 - initial release
// ============================================================================
module exception_commit_unit #(
    parameter int               NUM_SLOTS   = 2,
    parameter int               EXC_W       = 19,
    parameter int               CODE_W      = 5,
    parameter int               REFETCH_IDX = 0,
    parameter int               ERET_IDX    = 9,
    parameter int               INT_IDX     = 1,
    parameter logic [EXC_W-1:0] TLBR_MASK   = 19'h0A008,
    parameter int               DRAIN_CYC   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    exception_commit_unit_if.slave bus
);

    localparam int          c_slot_w   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int          c_cnt_w    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [31:0] c_bev_base = 32'hBFC0_0200;
    localparam logic [31:0] c_gen_off  = 32'h0000_0180;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_int_pending;
    logic                r_int_commit;    // current decision is an interrupt
    logic                r_flush;
    logic [CODE_W-1:0]   r_code;
    logic [1:0]          r_entry_sel;
    logic [31:0]         r_vector;
    logic [31:0]         r_epc;
    logic                r_bd;
    logic [c_slot_w-1:0] r_slot;

    // ------------------------------------------------------------------
    // Combinational decision
    // ------------------------------------------------------------------
    logic [EXC_W-1:0]    w_bits [NUM_SLOTS];
    logic [31:0]         w_pc   [NUM_SLOTS];
    logic                w_found;
    logic [c_slot_w-1:0] w_sel_slot;
    logic                w_int_take;
    logic [EXC_W-1:0]    w_sel_bits;
    logic [31:0]         w_sel_pc;
    logic                w_sel_bd;
    logic [CODE_W-1:0]   w_cause_idx;
    logic                w_tlb;
    logic [CODE_W-1:0]   w_code;
    logic [1:0]          w_entry_sel;
    logic [31:0]         w_vector;
    logic [31:0]         w_epc;
    logic                w_int_req;

    state_t              w_state_next;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic                w_commit;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_bits[gi] = bus.Slot_ExcBits[gi*EXC_W +: EXC_W];
            assign w_pc[gi]   = bus.Slot_PC[gi*32 +: 32];
        end
    endgenerate

    // Walk slots oldest-first. The first valid slot met is the oldest valid
    // one, which is the only slot an interrupt may attach to. The first slot
    // that qualifies wins; everything younger is discarded.
    always_comb begin
        logic v_first;
        v_first    = 1'b1;
        w_found    = 1'b0;
        w_sel_slot = '0;
        w_int_take = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.Slot_Valid[i] && !w_found) begin
                if ((w_bits[i] != '0) || (v_first && r_int_pending)) begin
                    w_found    = 1'b1;
                    w_sel_slot = c_slot_w'(i);
                    // Refetch is the one cause an interrupt cannot override
                    w_int_take = v_first && r_int_pending && !w_bits[i][REFETCH_IDX];
                end
                v_first = 1'b0;
            end
        end
    end

    assign w_sel_bits = w_bits[w_sel_slot];
    assign w_sel_pc   = w_pc[w_sel_slot];
    assign w_sel_bd   = bus.Slot_InDelay[w_sel_slot];

    // Lowest set bit is the highest-priority cause; scan high-to-low so the
    // last hit is the lowest index.
    always_comb begin
        w_cause_idx = '0;
        w_tlb       = 1'b0;
        for (int j = EXC_W - 1; j >= 0; j--) begin
            if (w_sel_bits[j]) begin
                w_cause_idx = CODE_W'(j);
                w_tlb       = TLBR_MASK[j];
            end
        end
        if (w_int_take) begin
            w_cause_idx = CODE_W'(INT_IDX);
            w_tlb       = TLBR_MASK[INT_IDX];
        end
    end

    assign w_code = w_cause_idx + CODE_W'(1);

    always_comb begin
        w_entry_sel = 2'd1;
        if (w_cause_idx == CODE_W'(REFETCH_IDX)) begin
            w_entry_sel = 2'd3;
        end else if (w_cause_idx == CODE_W'(ERET_IDX)) begin
            w_entry_sel = 2'd2;
        end
    end

    // TLB refill gets the dedicated offset-0 entry only outside EXL; a
    // nested refill goes to the general vector. Sum wraps naturally.
    assign w_vector = (bus.CP0_Status_BEV ? c_bev_base : bus.CP0_Ebase)
                    + ((w_tlb && !bus.CP0_Status_EXL) ? 32'h0 : c_gen_off);

    assign w_epc     = w_sel_bd ? (w_sel_pc - 32'd4) : w_sel_pc;
    assign w_int_req = bus.Interrupt_Req && bus.CP0_Status_IE && !bus.CP0_Status_EXL;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.MEM_Stall && w_found) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (DRAIN_CYC > 0) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = c_cnt_w'(DRAIN_CYC - 1);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and decision registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_int_pending <= 1'b0;
            r_int_commit  <= 1'b0;
            r_flush       <= 1'b0;
            r_code        <= '0;
            r_entry_sel   <= 2'd0;
            r_vector      <= 32'h0;
            r_epc         <= 32'h0;
            r_bd          <= 1'b0;
            r_slot        <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_flush <= w_commit;
            // The interrupt is consumed in its own commit cycle; a request
            // still asserted afterwards re-latches on the following edge.
            r_int_pending <= w_int_req && !((r_state == ST_COMMIT) && r_int_commit);
            if (w_commit) begin
                r_int_commit <= w_int_take;
                r_code       <= w_code;
                r_entry_sel  <= w_entry_sel;
                r_vector     <= w_vector;
                r_epc        <= w_epc;
                r_bd         <= w_sel_bd;
                r_slot       <= w_sel_slot;
            end
        end
    end

    assign bus.Flush_Exception  = r_flush;
    assign bus.MEM_ExcType      = r_code;
    assign bus.EX_Entry_Sel     = r_entry_sel;
    assign bus.Exception_Vector = r_vector;
    assign bus.Exc_EPC          = r_epc;
    assign bus.Exc_BD           = r_bd;
    assign bus.Exc_Slot         = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_exception_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exception_commit_unit
// Description : Self-checking bench for exception_commit_unit: vector table,
//               directed multi-cycle sequences and a randomized run against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exception_commit_unit;

    localparam int DRAIN = 2;

    logic clk;
    logic rst;

    exception_commit_unit_if #(.NUM_SLOTS(2), .EXC_W(19), .CODE_W(5)) bus ();

    exception_commit_unit #(.NUM_SLOTS(2), .EXC_W(19), .CODE_W(5), .DRAIN_CYC(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        flush;
        logic [4:0]  code;
        logic [1:0]  sel;
        logic [31:0] vec;
        logic [31:0] epc;
        logic        bd;
        logic        slot;
    } out_t;

    typedef struct {
        logic [1:0]  valid;
        logic [18:0] bits0;
        logic [18:0] bits1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  indelay;
        logic        req;
        logic        ie;
        logic        exl;
        logic        bev;
        logic [31:0] ebase;
        out_t        exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    out_t m_out;
    logic m_pend;
    logic m_int_commit;
    int   m_blank;      // edges still to be ignored after a commit

    function automatic logic ref_decide(input logic pend, output out_t d, output logic is_int);
        logic [18:0] b [2];
        logic [31:0] pc [2];
        logic [31:0] base;
        logic [31:0] off;
        int oldest;
        int pick;
        int cause;
        b[0]  = bus.Slot_ExcBits[18:0];
        b[1]  = bus.Slot_ExcBits[37:19];
        pc[0] = bus.Slot_PC[31:0];
        pc[1] = bus.Slot_PC[63:32];
        d      = '0;
        is_int = 1'b0;
        oldest = -1;
        pick   = -1;
        cause  = -1;
        for (int i = 0; i < 2; i++)
            if (bus.Slot_Valid[i] && oldest < 0) oldest = i;
        for (int i = 0; i < 2; i++)
            if (pick < 0 && bus.Slot_Valid[i] && (b[i] != 0 || (i == oldest && pend))) pick = i;
        if (pick < 0) return 1'b0;
        is_int = pend && (pick == oldest) && !b[pick][0];
        if (is_int) cause = 1;
        else for (int k = 18; k >= 0; k--) if (b[pick][k]) cause = k;
        d.flush = 1'b1;
        d.code  = 5'(cause + 1);
        d.sel   = (cause == 0) ? 2'd3 : (cause == 9) ? 2'd2 : 2'd1;
        base    = bus.CP0_Status_BEV ? 32'hBFC00200 : bus.CP0_Ebase;
        // TLB refill causes: IF (3), RdMEM (13), WrMEM (15)
        off     = ((cause == 3 || cause == 13 || cause == 15) && !bus.CP0_Status_EXL) ? 32'h0 : 32'h180;
        d.vec   = base + off;
        d.bd    = bus.Slot_InDelay[pick];
        d.epc   = d.bd ? pc[pick] - 32'd4 : pc[pick];
        d.slot  = pick[0];
        return 1'b1;
    endfunction

    task automatic model_step();
        out_t d;
        logic is_int;
        logic new_pend;
        if (rst) begin
            m_out        = '0;
            m_pend       = 1'b0;
            m_int_commit = 1'b0;
            m_blank      = 0;
        end else begin
            new_pend = bus.Interrupt_Req && bus.CP0_Status_IE && !bus.CP0_Status_EXL
                       && !(m_out.flush && m_int_commit);
            m_out.flush = 1'b0;
            if (m_blank > 0) begin
                m_blank--;
            end else if (!bus.MEM_Stall && ref_decide(m_pend, d, is_int)) begin
                m_out        = d;
                m_blank      = 1 + DRAIN;
                m_int_commit = is_int;
            end
            m_pend = new_pend;
        end
    endtask

    // One clock: model follows the edge, return at the falling edge where
    // outputs are sampled and new inputs are driven.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.flush = bus.Flush_Exception;
        o.code  = bus.MEM_ExcType;
        o.sel   = bus.EX_Entry_Sel;
        o.vec   = bus.Exception_Vector;
        o.epc   = bus.Exc_EPC;
        o.bd    = bus.Exc_BD;
        o.slot  = bus.Exc_Slot;
        return o;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = dut_out();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got flush=%0b code=%0d sel=%0d vec=%h epc=%h bd=%0b slot=%0d; want flush=%0b code=%0d sel=%0d vec=%h epc=%h bd=%0b slot=%0d",
                     name, act.flush, act.code, act.sel, act.vec, act.epc, act.bd, act.slot,
                     exp.flush, exp.code, exp.sel, exp.vec, exp.epc, exp.bd, exp.slot);
        end
    endtask

    task automatic idle_inputs();
        bus.Slot_Valid     = 2'b00;
        bus.Slot_ExcBits   = '0;
        bus.Slot_PC        = '0;
        bus.Slot_InDelay   = 2'b00;
        bus.MEM_Stall      = 1'b0;
        bus.Interrupt_Req  = 1'b0;
        bus.CP0_Status_IE  = 1'b0;
        bus.CP0_Status_EXL = 1'b0;
        bus.CP0_Status_BEV = 1'b0;
        bus.CP0_Ebase      = 32'h80000000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        do_reset();
        bus.Slot_ExcBits   = {v.bits1, v.bits0};
        bus.Slot_PC        = {v.pc1, v.pc0};
        bus.Slot_InDelay   = v.indelay;
        bus.Interrupt_Req  = v.req;
        bus.CP0_Status_IE  = v.ie;
        bus.CP0_Status_EXL = v.exl;
        bus.CP0_Status_BEV = v.bev;
        bus.CP0_Ebase      = v.ebase;
        tick();                 // lets the interrupt latch before slots go valid
        bus.Slot_Valid = v.valid;
        tick();
        check($sformatf("vec%0d", idx), v.exp);
    endtask

    vec_t tbl [15];

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_out = '0; m_pend = 1'b0; m_int_commit = 1'b0; m_blank = 0;

        //         valid  bits0     bits1     pc0           pc1           dly    req   ie    exl   bev   ebase          flush code sel vec           epc           bd    slot
        tbl[0]  = '{2'b11, 19'h00000, 19'h00080, 32'h80000FFC, 32'h80001000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd8,  2'd1, 32'h80000180, 32'h80001000, 1'b0, 1'b1}};
        tbl[1]  = '{2'b11, 19'h00800, 19'h00001, 32'h80002000, 32'h80002004, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd12, 2'd1, 32'h80000180, 32'h80002000, 1'b0, 1'b0}};
        tbl[2]  = '{2'b01, 19'h02000, 19'h00000, 32'hBFC00010, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, '{1'b1, 5'd14, 2'd1, 32'hBFC00200, 32'hBFC00010, 1'b0, 1'b0}};
        tbl[3]  = '{2'b01, 19'h02000, 19'h00000, 32'hBFC00010, 32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, '{1'b1, 5'd14, 2'd1, 32'hBFC00380, 32'hBFC00010, 1'b0, 1'b0}};
        tbl[4]  = '{2'b01, 19'h00200, 19'h00000, 32'h80003000, 32'h0,        2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd2,  2'd1, 32'h80000180, 32'h80003000, 1'b0, 1'b0}};
        tbl[5]  = '{2'b01, 19'h00200, 19'h00000, 32'h80003000, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd10, 2'd2, 32'h80000180, 32'h80003000, 1'b0, 1'b0}};
        tbl[6]  = '{2'b01, 19'h00001, 19'h00000, 32'h80003000, 32'h0,        2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd1,  2'd3, 32'h80000180, 32'h80003000, 1'b0, 1'b0}};
        tbl[7]  = '{2'b01, 19'h00010, 19'h00000, 32'h00000100, 32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd5,  2'd1, 32'h80000180, 32'h000000FC, 1'b1, 1'b0}};
        tbl[8]  = '{2'b10, 19'h00000, 19'h00000, 32'h0,        32'h80004004, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd2,  2'd1, 32'h80000180, 32'h80004000, 1'b1, 1'b1}};
        tbl[9]  = '{2'b01, 19'h00004, 19'h00000, 32'h80005000, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFF00, '{1'b1, 5'd3,  2'd1, 32'h00000080, 32'h80005000, 1'b0, 1'b0}};
        tbl[10] = '{2'b11, 19'h00000, 19'h00000, 32'h80005000, 32'h80005004, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, '{1'b0, 5'd0,  2'd0, 32'h0,        32'h0,        1'b0, 1'b0}};
        tbl[11] = '{2'b11, 19'h00000, 19'h00000, 32'h80005000, 32'h80005004, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80000000, '{1'b0, 5'd0,  2'd0, 32'h0,        32'h0,        1'b0, 1'b0}};
        tbl[12] = '{2'b01, 19'h00008, 19'h00000, 32'h80006000, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd4,  2'd1, 32'h80000000, 32'h80006000, 1'b0, 1'b0}};
        tbl[13] = '{2'b10, 19'h00020, 19'h00040, 32'h80007000, 32'h80007004, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, '{1'b1, 5'd7,  2'd1, 32'h80000180, 32'h80007004, 1'b0, 1'b1}};
        tbl[14] = '{2'b01, 19'h00000, 19'h00000, 32'h80008000, 32'h0,        2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, '{1'b0, 5'd0,  2'd0, 32'h0,        32'h0,        1'b0, 1'b0}};

        // reset state
        do_reset();
        check("reset", '0);

        for (int i = 0; i < 15; i++) apply_vec(tbl[i], i);

        // stall holds the commit; then flush, drain blanking, re-commit
        do_reset();
        bus.Slot_Valid   = 2'b01;
        bus.Slot_ExcBits = {19'h0, 19'h00080};
        bus.Slot_PC      = {32'h0, 32'h80008000};
        bus.MEM_Stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", '0);
        end
        bus.MEM_Stall = 1'b0;
        tick();
        check("stall_release", '{1'b1, 5'd8, 2'd1, 32'h80000180, 32'h80008000, 1'b0, 1'b0});
        bus.Slot_ExcBits = {19'h0, 19'h00800};    // new cause during drain is ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_blank", '{1'b0, 5'd8, 2'd1, 32'h80000180, 32'h80008000, 1'b0, 1'b0});
        end
        tick();
        check("recommit", '{1'b1, 5'd12, 2'd1, 32'h80000180, 32'h80008000, 1'b0, 1'b0});

        // reset during the commit cycle drops the decision
        do_reset();
        bus.Slot_Valid   = 2'b01;
        bus.Slot_ExcBits = {19'h0, 19'h00010};
        bus.Slot_PC      = {32'h0, 32'h00000100};
        bus.Slot_InDelay = 2'b01;
        tick();
        check("pre_rst_commit", '{1'b1, 5'd5, 2'd1, 32'h80000180, 32'h000000FC, 1'b1, 1'b0});
        rst = 1'b1;
        bus.Slot_Valid = 2'b00;
        tick();
        check("rst_in_commit", '0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_second_flush", '0);
        end

        // interrupt beats Eret, then is not re-taken once EXL masks it
        do_reset();
        bus.Interrupt_Req = 1'b1;
        bus.CP0_Status_IE = 1'b1;
        bus.Slot_ExcBits  = {19'h0, 19'h00200};
        bus.Slot_PC       = {32'h0, 32'h80009000};
        tick();
        bus.Slot_Valid = 2'b01;
        tick();
        check("int_commit", '{1'b1, 5'd2, 2'd1, 32'h80000180, 32'h80009000, 1'b0, 1'b0});
        bus.CP0_Status_EXL = 1'b1;
        bus.Slot_ExcBits   = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("int_masked", '{1'b0, 5'd2, 2'd1, 32'h80000180, 32'h80009000, 1'b0, 1'b0});
        end

        // randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [18:0] b [2];
            rst = ($urandom_range(0, 63) == 0);
            for (int s = 0; s < 2; s++) begin
                case ($urandom_range(0, 3))
                    0:       b[s] = 19'h0;
                    1:       b[s] = 19'h1 << $urandom_range(0, 18);
                    2:       b[s] = 19'($urandom);
                    default: b[s] = 19'h0;
                endcase
            end
            bus.Slot_Valid     = 2'($urandom);
            bus.Slot_ExcBits   = {b[1], b[0]};
            bus.Slot_PC        = {$urandom, $urandom};
            bus.Slot_InDelay   = 2'($urandom);
            bus.MEM_Stall      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) bus.Interrupt_Req = ~bus.Interrupt_Req;
            bus.CP0_Status_IE  = ($urandom_range(0, 4) != 0);
            bus.CP0_Status_EXL = ($urandom_range(0, 4) == 0);
            bus.CP0_Status_BEV = ($urandom_range(0, 3) == 0);
            bus.CP0_Ebase      = $urandom & 32'hFFFF_F000;
            tick();
            check("random", m_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
